// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] PC_STEP          = 64'd4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus bundle: instruction memory port, execute-stage redirect
// and the IF/ID hand-off. master = fetch stage, slave = memory/pipeline side.
interface fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc, id_stall,
        output if_valid, if_instr, if_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc, id_stall,
        input  if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Storage is not reset; readers only look at it while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + AW'(1);
            if (pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign head  = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with credit-limited prefetch and redirect squashing.
// Optional FETCH_PERF_EN adds pop and stall performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [63:0]   r_fetch_pc;
    logic [63:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic          w_req;
    logic          w_fire;
    logic          w_accept;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_inflight;
    fetch_entry_t  w_din;
    fetch_entry_t  w_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_BOOT;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_BOOT;
        endcase
    end

    // Credits cover both queued words and words still in flight, so a granted
    // request always has a slot waiting for it.
    always_comb begin
        w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
        w_req      = (r_state == ST_RUN) && !bus.redirect_valid
                     && (w_inflight < (CW+1)'(FIFO_DEPTH));
    end

    assign w_fire   = w_req && bus.imem_gnt;
    assign w_drop   = bus.imem_rvalid && (r_drop_cnt != '0);
    assign w_accept = bus.imem_rvalid && (r_drop_cnt == '0) && !bus.redirect_valid;
    assign w_pop    = !w_empty && !bus.id_stall && !bus.redirect_valid;
    assign w_push   = w_accept && (!w_full || w_pop);
    assign w_din    = '{pc: r_resp_pc, instr: bus.imem_rdata};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= align_pc(RESET_PC);
            r_resp_pc     <= align_pc(RESET_PC);
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_fire) - CW'(bus.imem_rvalid);
            if (bus.redirect_valid) begin
                // Everything still in flight after this cycle's response is stale.
                r_fetch_pc <= align_pc(bus.redirect_pc);
                r_resp_pc  <= align_pc(bus.redirect_pc);
                r_drop_cnt <= r_outstanding - CW'(bus.imem_rvalid);
            end else begin
                if (w_fire)   r_fetch_pc <= r_fetch_pc + PC_STEP;
                if (w_accept) r_resp_pc  <= r_resp_pc + PC_STEP;
                if (w_drop)   r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (bus.redirect_valid),
        .din   (w_din),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head),
        .count (w_count)
    );

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.if_valid  = !w_empty;
    assign bus.if_instr  = w_empty ? 32'h0 : w_head.instr;
    assign bus.if_pc     = w_empty ? 64'h0 : w_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop)                   r_perf_fetched <= r_perf_fetched + 32'd1;
            if (!w_empty && bus.id_stall) r_perf_stall  <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// phase checked against a stream model (contiguous PCs from the last target).
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_stage #(
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          gnt_pct, rv_pct, lat_max;
    int          n_pop, n_stall;
    logic [63:0] pend_addr[$];
    int          pend_rdy[$];
    logic [63:0] exp_req, exp_pop;
    logic        s_req, s_valid;
    logic [63:0] s_addr, s_pc;

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] memfn(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, update the model.
    task automatic cycle(input bit redir, input logic [63:0] rpc, input bit stall);
        bit gnt;
        bit rv;
        bus.id_stall       = stall;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        gnt = ($urandom_range(99) < gnt_pct);
        rv  = (pend_addr.size() > 0) && (pend_rdy[0] <= cyc) && ($urandom_range(99) < rv_pct);
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        if (rv) bus.imem_rdata = memfn(pend_addr[0]);
        else    bus.imem_rdata = $urandom;
        #3;
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = bus.if_valid;
        s_pc    = bus.if_pc;
        if (redir) check("req_in_redirect", s_req, 0);
        if (s_req && gnt) begin
            check("imem_addr", s_addr, exp_req);
            exp_req += 64'd4;
            pend_addr.push_back(s_addr);
            pend_rdy.push_back(cyc + 1 + $urandom_range(lat_max));
            check("credit_limit", 64'(pend_addr.size() <= DEPTH), 1);
        end
        if (s_valid && !stall && !redir) begin
            check("if_pc", s_pc, exp_pop);
            check("if_instr", bus.if_instr, memfn(exp_pop));
            exp_pop += 64'd4;
            n_pop++;
        end
        if (s_valid && stall) n_stall++;
        if (redir) begin
            exp_req = rpc & ~64'h3;
            exp_pop = rpc & ~64'h3;
        end
        if (rv) begin
            void'(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle(1'b0, 64'h0, 1'b0);
            if (s_valid) break;
        end
        check("valid_timeout", s_valid, 1);
    endtask

    task automatic set_det();
        gnt_pct = 100;
        rv_pct  = 100;
        lat_max = 0;
    endtask

    initial begin
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_stall = 1'b0;
        set_det();
        exp_req = '0; exp_pop = '0; n_pop = 0; n_stall = 0;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   bus.imem_req,  0);
        check("rst_valid", bus.if_valid,  0);
        check("rst_instr", bus.if_instr,  0);
        check("rst_pc",    bus.if_pc,     0);
        check("rst_addr",  bus.imem_addr, 0);

        // Boot cycle, first request, one-cycle latency, sequence 0/4/8
        rst = 1'b1;
        cycle(0, 0, 0); check("boot_req", s_req, 0);
        cycle(0, 0, 0); check("first_req", s_req, 1); check("first_addr", s_addr, 0);
        cycle(0, 0, 0); check("latency_gap", s_valid, 0);
        cycle(0, 0, 0); check("first_valid", s_valid, 1); check("pc_seq0", s_pc, 64'h0);
        cycle(0, 0, 0); check("pc_seq1", s_pc, 64'h4);
        cycle(0, 0, 0); check("pc_seq2", s_pc, 64'h8);

        // Stall for 10 cycles: queue fills, requests stop, exactly 4 held
        repeat (10) cycle(0, 0, 1);
        check("stall_req_drop", s_req, 0);
        check("stall_valid", s_valid, 1);
        gnt_pct = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0);
            check("drain_valid", s_valid, 1);
        end
        cycle(0, 0, 0); check("fifo_held_4", s_valid, 0);
        gnt_pct = 100;
        repeat (6) cycle(0, 0, 0);

        // Redirect to 0x1002 with two responses outstanding
        gnt_pct = 0;
        repeat (6) cycle(0, 0, 0);
        gnt_pct = 100; rv_pct = 0;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 64'h1002, 0);
        rv_pct = 100;
        cycle(0, 0, 0); check("redir_req", s_req, 1); check("redir_addr", s_addr, 64'h1000);
        wait_valid(20);
        check("redir_pc", s_pc, 64'h1000);

        // Redirect coincident with a response and a valid head
        set_det();
        repeat (6) cycle(0, 0, 0);
        cycle(1, 64'h2000, 0); check("redir_old_head", s_valid, 1);
        cycle(0, 0, 0);        check("flush_empty", s_valid, 0);
        wait_valid(20);
        check("redir2_pc", s_pc, 64'h2000);

        // Address wrap-around
        cycle(1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        cycle(0, 0, 0); check("wrap_addr0", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(0, 0, 0); check("wrap_addr1", s_addr, 64'h0);
        wait_valid(20);
        check("wrap_pc0", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(0, 0, 0); check("wrap_pc1", s_pc, 64'h0);

        // Randomized traffic: grants, latency, stalls and redirects
        gnt_pct = 60; rv_pct = 70; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) < 3), {$urandom, $urandom}, ($urandom_range(99) < 30));
        end
        gnt_pct = 0; rv_pct = 100;
        repeat (30) cycle(0, 0, 0);
        check("rand_drained", s_valid, 0);

        // Asynchronous reset mid-operation
        set_det();
        repeat (5) cycle(0, 0, 0);
        rst = 1'b0;
        #1;
        check("async_rst_req", bus.imem_req, 0);
        check("async_rst_valid", bus.if_valid, 0);
        bus.imem_rvalid = 1'b0;
        pend_addr.delete();
        pend_rdy.delete();
        exp_req = '0; exp_pop = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        n_pop = 0; n_stall = 0;
        cycle(0, 0, 0); check("reboot_req", s_req, 0);
        wait_valid(20);
        check("post_rst_pc", s_pc, 64'h0);
        repeat (3) cycle(0, 0, 1);
        repeat (4) cycle(0, 0, 0);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 5);
        check("perf_stall", perf_stall, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
